// File: rtl/multicycle_ctrl_fsm.sv
// Moore control FSM for a multicycle MIPS datapath: fetch/decode/execute sequencing,
// memory wait handling, illegal-opcode pulse and halt.
module multicycle_ctrl_fsm #(
  parameter int unsigned         OP_W    = 6,
  parameter logic [OP_W-1:0]     HALT_OP = 6'b111111
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [OP_W-1:0] opcode,
  input  logic            zero,
  input  logic            mem_ready,
  output logic            pc_write,
  output logic            pc_write_cond,
  output logic            iord,
  output logic            mem_read,
  output logic            mem_write,
  output logic            ir_write,
  output logic            mem_to_reg,
  output logic            reg_dst,
  output logic            reg_write,
  output logic            alu_src_a,
  output logic [1:0]      alu_src_b,
  output logic [1:0]      alu_op,
  output logic [1:0]      pc_src,
  output logic            illegal,
  output logic            halted,
  output logic [3:0]      state_dbg
);

  localparam logic [OP_W-1:0] OpLw   = OP_W'(6'b100011);
  localparam logic [OP_W-1:0] OpSw   = OP_W'(6'b101011);
  localparam logic [OP_W-1:0] OpR    = OP_W'(6'b000000);
  localparam logic [OP_W-1:0] OpBeq  = OP_W'(6'b000100);
  localparam logic [OP_W-1:0] OpAddi = OP_W'(6'b001000);
  localparam logic [OP_W-1:0] OpJ    = OP_W'(6'b000010);

  typedef enum logic [3:0] {
    StIdle   = 4'd0,
    StFetch  = 4'd1,
    StDecode = 4'd2,
    StMemAdr = 4'd3,
    StMemRd  = 4'd4,
    StMemWb  = 4'd5,
    StMemWr  = 4'd6,
    StExec   = 4'd7,
    StRwb    = 4'd8,
    StBranch = 4'd9,
    StAddiEx = 4'd10,
    StAddiWb = 4'd11,
    StJump   = 4'd12,
    StHalt   = 4'd13
  } state_e;

  state_e state_q, state_d;
  logic   illegal_q, illegal_d;

  // zero only gates pc_write_cond inside the datapath; the FSM itself never looks at it.
  logic unused_zero;
  assign unused_zero = zero;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    illegal_d = 1'b0;
    case (state_q)
      StIdle:   state_d = StFetch;
      StFetch:  if (mem_ready) state_d = StDecode;
      StDecode: begin
        case (opcode)
          OpLw, OpSw: state_d = StMemAdr;
          OpR:        state_d = StExec;
          OpBeq:      state_d = StBranch;
          OpAddi:     state_d = StAddiEx;
          OpJ:        state_d = StJump;
          HALT_OP:    state_d = StHalt;
          default: begin
            state_d   = StFetch;
            illegal_d = 1'b1;
          end
        endcase
      end
      StMemAdr: state_d = (opcode == OpLw) ? StMemRd : StMemWr;
      StMemRd:  if (mem_ready) state_d = StMemWb;
      StMemWb:  state_d = StFetch;
      StMemWr:  if (mem_ready) state_d = StFetch;
      StExec:   state_d = StRwb;
      StRwb:    state_d = StFetch;
      StBranch: state_d = StFetch;
      StAddiEx: state_d = StAddiWb;
      StAddiWb: state_d = StFetch;
      StJump:   state_d = StFetch;
      StHalt:   state_d = StHalt;
      default:  state_d = StIdle;
    endcase
  end

  // Moore outputs: a pure function of the registered state.
  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    iord          = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_to_reg    = 1'b0;
    reg_dst       = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    alu_op        = 2'b00;
    pc_src        = 2'b00;
    halted        = 1'b0;
    case (state_q)
      StFetch: begin
        mem_read  = 1'b1;
        ir_write  = 1'b1;
        alu_src_b = 2'b01;
        pc_write  = 1'b1;
      end
      StDecode: alu_src_b = 2'b11;
      StMemAdr: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      StMemRd: begin
        mem_read = 1'b1;
        iord     = 1'b1;
      end
      StMemWb: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      StMemWr: begin
        mem_write = 1'b1;
        iord      = 1'b1;
      end
      StExec: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
      end
      StRwb: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
      end
      StBranch: begin
        alu_src_a     = 1'b1;
        alu_op        = 2'b01;
        pc_src        = 2'b01;
        pc_write_cond = 1'b1;
      end
      StAddiEx: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      StAddiWb: reg_write = 1'b1;
      StJump: begin
        pc_write = 1'b1;
        pc_src   = 2'b10;
      end
      StHalt:  halted = 1'b1;
      default: ;
    endcase
  end

  assign illegal   = illegal_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Self-checking bench for multicycle_ctrl_fsm: per-instruction expected state traces built from
// the instruction set rules, checked cycle by cycle with randomized wait states and inputs.
module tb_multicycle_ctrl_fsm;

  localparam int S_IDLE = 0, S_FETCH = 1, S_DECODE = 2, S_MEMADR = 3, S_MEMRD = 4, S_MEMWB = 5;
  localparam int S_MEMWR = 6, S_EXEC = 7, S_RWB = 8, S_BRANCH = 9, S_ADDIEX = 10;
  localparam int S_ADDIWB = 11, S_JUMP = 12, S_HALT = 13;

  localparam logic [5:0] OP_LW = 6'b100011, OP_SW = 6'b101011, OP_R = 6'b000000;
  localparam logic [5:0] OP_BEQ = 6'b000100, OP_ADDI = 6'b001000, OP_J = 6'b000010;
  localparam logic [5:0] OP_HALT = 6'b111111;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] opcode = '0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic       pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write;
  logic       mem_to_reg, reg_dst, reg_write, alu_src_a, illegal, halted;
  logic [1:0] alu_src_b, alu_op, pc_src;
  logic [3:0] state_dbg;

  int checks = 0;
  int failures = 0;
  bit expect_illegal = 1'b0;

  multicycle_ctrl_fsm #(.OP_W(6), .HALT_OP(6'b111111)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .iord(iord), .mem_read(mem_read),
    .mem_write(mem_write), .ir_write(ir_write), .mem_to_reg(mem_to_reg), .reg_dst(reg_dst),
    .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .pc_src(pc_src), .illegal(illegal), .halted(halted), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [16:0] act_ctrl();
    return {pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write, mem_to_reg, reg_dst,
            reg_write, alu_src_a, alu_src_b, alu_op, pc_src, halted};
  endfunction

  // Control word demanded in each state by the datapath's needs.
  function automatic logic [16:0] exp_ctrl(input int s);
    logic pw = 0, pwc = 0, io = 0, mr = 0, mw = 0, irw = 0, m2r = 0, rd = 0, rw = 0, sa = 0;
    logic hl = 0;
    logic [1:0] sb = 0, op = 0, ps = 0;
    case (s)
      S_FETCH:  begin mr = 1; irw = 1; sb = 2'b01; pw = 1; end
      S_DECODE: sb = 2'b11;
      S_MEMADR: begin sa = 1; sb = 2'b10; end
      S_MEMRD:  begin mr = 1; io = 1; end
      S_MEMWB:  begin rw = 1; m2r = 1; end
      S_MEMWR:  begin mw = 1; io = 1; end
      S_EXEC:   begin sa = 1; op = 2'b10; end
      S_RWB:    begin rw = 1; rd = 1; end
      S_BRANCH: begin sa = 1; op = 2'b01; ps = 2'b01; pwc = 1; end
      S_ADDIEX: begin sa = 1; sb = 2'b10; end
      S_ADDIWB: rw = 1;
      S_JUMP:   begin pw = 1; ps = 2'b10; end
      S_HALT:   hl = 1;
      default: ;
    endcase
    return {pw, pwc, io, mr, mw, irw, m2r, rd, rw, sa, sb, op, ps, hl};
  endfunction

  function automatic bit is_illegal_op(input logic [5:0] op);
    return !(op inside {OP_LW, OP_SW, OP_R, OP_BEQ, OP_ADDI, OP_J, OP_HALT});
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs one instruction starting in FETCH: fw fetch wait cycles, mw data-memory wait cycles.
  task automatic run_instr(input string name, input logic [5:0] op, input int fw, input int mw);
    int st[$];
    bit rdy[$];
    for (int k = 0; k < fw; k++) begin st.push_back(S_FETCH); rdy.push_back(0); end
    st.push_back(S_FETCH); rdy.push_back(1);
    st.push_back(S_DECODE); rdy.push_back(1'($urandom));
    if (op == OP_LW || op == OP_SW) begin
      int ph = (op == OP_LW) ? S_MEMRD : S_MEMWR;
      st.push_back(S_MEMADR); rdy.push_back(1'($urandom));
      for (int k = 0; k < mw; k++) begin st.push_back(ph); rdy.push_back(0); end
      st.push_back(ph); rdy.push_back(1);
      if (op == OP_LW) begin st.push_back(S_MEMWB); rdy.push_back(1'($urandom)); end
    end else if (op == OP_R) begin
      st.push_back(S_EXEC); st.push_back(S_RWB);
      rdy.push_back(1'($urandom)); rdy.push_back(1'($urandom));
    end else if (op == OP_BEQ) begin
      st.push_back(S_BRANCH); rdy.push_back(1'($urandom));
    end else if (op == OP_ADDI) begin
      st.push_back(S_ADDIEX); st.push_back(S_ADDIWB);
      rdy.push_back(1'($urandom)); rdy.push_back(1'($urandom));
    end else if (op == OP_J) begin
      st.push_back(S_JUMP); rdy.push_back(1'($urandom));
    end
    for (int i = 0; i < st.size(); i++) begin
      checks++;
      if (state_dbg !== 4'(st[i])) begin
        failures++;
        $display("FAIL %s state step %0d: got %0d expected %0d", name, i, state_dbg, st[i]);
      end
      checks++;
      if (act_ctrl() !== exp_ctrl(st[i])) begin
        failures++;
        $display("FAIL %s ctrl step %0d: got %h expected %h", name, i, act_ctrl(),
                 exp_ctrl(st[i]));
      end
      checks++;
      if (illegal !== (i == 0 && expect_illegal)) begin
        failures++;
        $display("FAIL %s illegal step %0d: got %b expected %b", name, i, illegal,
                 (i == 0 && expect_illegal));
      end
      checks++;
      if (mem_read === 1'b1 && mem_write === 1'b1) begin
        failures++;
        $display("FAIL %s mem_rw_exclusive step %0d: got both 1 expected not both", name, i);
      end
      opcode    = (st[i] == S_FETCH) ? 6'($urandom) : op;
      mem_ready = rdy[i];
      zero      = 1'($urandom);
      tick();
    end
    checks++;
    if (state_dbg !== ((op == OP_HALT) ? 4'(S_HALT) : 4'(S_FETCH))) begin
      failures++;
      $display("FAIL %s end_state: got %0d expected %0d", name, state_dbg,
               (op == OP_HALT) ? S_HALT : S_FETCH);
    end
    expect_illegal = is_illegal_op(op);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    mem_ready = 1'b1;
    repeat (2) tick();
    checks++;
    if (state_dbg !== 4'(S_IDLE) || act_ctrl() !== 17'h0 || illegal !== 1'b0) begin
      failures++;
      $display("FAIL reset_state: got state %0d ctrl %h illegal %b expected 0 0 0", state_dbg,
               act_ctrl(), illegal);
    end
    rst = 1'b0;
    opcode = OP_R;
    tick();
    checks++;
    if (state_dbg !== 4'(S_FETCH)) begin
      failures++;
      $display("FAIL idle_to_fetch: got %0d expected %0d", state_dbg, S_FETCH);
    end
  endtask

  task automatic test_r_type();
    run_instr("r_type", OP_R, 0, 0);
  endtask

  task automatic test_lw_wait();
    run_instr("lw_wait", OP_LW, 0, 3);
    run_instr("sw_wait", OP_SW, 2, 2);
  endtask

  task automatic test_branch();
    run_instr("beq", OP_BEQ, 0, 0);
    run_instr("jump", OP_J, 1, 0);
    run_instr("addi", OP_ADDI, 0, 0);
  endtask

  task automatic test_illegal();
    run_instr("illegal_op", 6'b010101, 0, 0);
    checks++;
    if (illegal !== 1'b1 || state_dbg !== 4'(S_FETCH) || reg_write !== 1'b0 ||
        mem_write !== 1'b0) begin
      failures++;
      $display("FAIL illegal_pulse: got illegal %b state %0d rw %b mw %b expected 1 1 0 0",
               illegal, state_dbg, reg_write, mem_write);
    end
    mem_ready = 1'b0;
    tick();
    expect_illegal = 1'b0;
    checks++;
    if (illegal !== 1'b0 || state_dbg !== 4'(S_FETCH)) begin
      failures++;
      $display("FAIL illegal_one_cycle: got illegal %b state %0d expected 0 1", illegal,
               state_dbg);
    end
  endtask

  task automatic test_random();
    logic [5:0] legal [6] = '{OP_LW, OP_SW, OP_R, OP_BEQ, OP_ADDI, OP_J};
    for (int n = 0; n < 60; n++) begin
      logic [5:0] op;
      if ($urandom_range(0, 5) == 0) begin
        do op = 6'($urandom); while (!is_illegal_op(op));
      end else begin
        op = legal[$urandom_range(0, 5)];
      end
      run_instr("random", op, $urandom_range(0, 3), $urandom_range(0, 3));
    end
  endtask

  task automatic test_halt();
    run_instr("halt_entry", OP_HALT, 0, 0);
    for (int i = 0; i < 20; i++) begin
      opcode = 6'($urandom);
      mem_ready = 1'($urandom);
      zero = 1'($urandom);
      tick();
      checks++;
      if (state_dbg !== 4'(S_HALT) || act_ctrl() !== exp_ctrl(S_HALT) || illegal !== 1'b0) begin
        failures++;
        $display("FAIL halt_hold cycle %0d: got state %0d ctrl %h expected %0d %h", i,
                 state_dbg, act_ctrl(), S_HALT, exp_ctrl(S_HALT));
      end
    end
    rst = 1'b1;
    tick();
    checks++;
    if (state_dbg !== 4'(S_IDLE) || act_ctrl() !== 17'h0) begin
      failures++;
      $display("FAIL halt_reset: got state %0d ctrl %h expected 0 0", state_dbg, act_ctrl());
    end
    rst = 1'b0;
    tick();
    expect_illegal = 1'b0;
    checks++;
    if (state_dbg !== 4'(S_FETCH)) begin
      failures++;
      $display("FAIL halt_restart: got %0d expected %0d", state_dbg, S_FETCH);
    end
  endtask

  task automatic test_reset_in_memwr();
    mem_ready = 1'b1;
    tick();
    opcode = OP_SW;
    tick();
    tick();
    checks++;
    if (state_dbg !== 4'(S_MEMWR) || mem_write !== 1'b1) begin
      failures++;
      $display("FAIL memwr_reach: got state %0d mw %b expected %0d 1", state_dbg, mem_write,
               S_MEMWR);
    end
    mem_ready = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    checks++;
    if (state_dbg !== 4'(S_IDLE) || mem_write !== 1'b0 || act_ctrl() !== 17'h0) begin
      failures++;
      $display("FAIL memwr_abort: got state %0d mw %b expected 0 0", state_dbg, mem_write);
    end
    rst = 1'b0;
    tick();
    checks++;
    if (state_dbg !== 4'(S_FETCH)) begin
      failures++;
      $display("FAIL memwr_restart: got %0d expected %0d", state_dbg, S_FETCH);
    end
    run_instr("after_abort", OP_R, 1, 0);
  endtask

  initial begin
    test_reset();
    test_r_type();
    test_lw_wait();
    test_branch();
    test_illegal();
    test_random();
    test_halt();
    test_reset_in_memwr();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
